// File: rtl/poseidon_audio_pkg.sv
// Shared constants, sample container and NCO helper for the guest-audio I2S path.
package poseidon_audio_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int AUDIO_SW   = 16;

  typedef struct packed {
    logic signed [AUDIO_SW-1:0] l;
    logic signed [AUDIO_SW-1:0] r;
  } stereo_t;

  // Phase increment per clk_sys cycle: two BCK edges per bit, FRAME_BITS bits per frame.
  // A ratio that could never produce a tick yields 0 so the caller's range check catches it.
  function automatic longint unsigned nco_inc(input longint unsigned clk_hz,
                                              input longint unsigned fs);
    longint unsigned inc;
    inc = 64'(2 * FRAME_BITS) * fs;
    if (inc >= clk_hz) inc = 64'd0;
    return inc;
  endfunction

endpackage

// File: rtl/i2s_bck_nco.sv
// Fractional NCO producing the I2S bit clock plus one-cycle rise/fall strobes.
module i2s_bck_nco
  import poseidon_audio_pkg::*;
#(
  parameter longint unsigned CLK_HZ    = 64'd50000000,
  parameter longint unsigned SAMPLE_HZ = 64'd48000,
  parameter int              ACC_W     = 32
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic bck,
  output logic tick_rise,
  output logic tick_fall
);

  localparam logic [ACC_W-1:0] INC   = ACC_W'(nco_inc(CLK_HZ, SAMPLE_HZ));
  localparam logic [ACC_W:0]   LIMIT = (ACC_W+1)'(CLK_HZ);

  if (CLK_HZ <= 64'(4 * FRAME_BITS) * SAMPLE_HZ) begin : g_bad_ratio
    $error("i2s_bck_nco: CLK_HZ must exceed 4*64*SAMPLE_HZ");
  end
  if (CLK_HZ >= (64'd1 << ACC_W)) begin : g_bad_acc
    $error("i2s_bck_nco: CLK_HZ does not fit the accumulator");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             bck_q, bck_d;
  logic [ACC_W:0]   sum;
  logic             wrap;

  // One spare bit holds acc+inc; acc < CLK_HZ and inc < CLK_HZ keep it from overflowing.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, INC};
    wrap  = (sum >= LIMIT);
    acc_d = wrap ? ACC_W'(sum - LIMIT) : sum[ACC_W-1:0];
    bck_d = bck_q ^ wrap;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      bck_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bck_q <= bck_d;
    end
  end

  // Strobes mark the cycle whose clock edge flips BCK, so consumers move with the pin.
  assign bck       = bck_q;
  assign tick_rise = wrap && !bck_q;
  assign tick_fall = wrap && bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: one-deep shadow buffer, frame-aligned load, repeat-on-underrun.
module i2s_audio_tx
  import poseidon_audio_pkg::*;
#(
  parameter longint unsigned CLK_HZ    = 64'd50000000,
  parameter longint unsigned SAMPLE_HZ = 64'd48000,
  parameter int              SW        = 16,
  parameter int              ACC_W     = 32
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [SW-1:0] left_in,
  input  logic [SW-1:0] right_in,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          underrun,
  output logic          I2S_BCK,
  output logic          I2S_LRCK,
  output logic          I2S_DATA
);

  if (SW < 8 || SW > 24) begin : g_bad_sw
    $error("i2s_audio_tx: SW must be 8..24");
  end

  logic          tick_fall, tick_rise_unused;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          lrck_q, lrck_d, data_q, data_d;
  logic          ready_q, ready_d, underrun_q, underrun_d;
  logic          shadow_full_q, shadow_full_d;
  logic [SW-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
  logic [SW-1:0] active_l_q, active_l_d, active_r_q, active_r_d;
  logic [SW-1:0] word, shifted;
  logic [4:0]    pos;

  i2s_bck_nco #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .ACC_W    (ACC_W)
  ) u_nco (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bck      (I2S_BCK),
    .tick_rise(tick_rise_unused),
    .tick_fall(tick_fall)
  );

  // Handshake: a transfer happens on any clk_sys edge where sample_valid && sample_ready;
  // ready is registered and low while the shadow holds an unplayed sample.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    underrun_d    = 1'b0;
    shadow_full_d = shadow_full_q;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;
    active_l_d    = active_l_q;
    active_r_d    = active_r_q;
    pos           = '0;
    word          = '0;
    shifted       = '0;

    if (sample_valid && ready_q) begin
      shadow_l_d    = left_in;
      shadow_r_d    = right_in;
      shadow_full_d = 1'b1;
    end

    if (tick_fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      // Load decisions use the pre-edge shadow_full, so a same-cycle arrival waits a frame.
      if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
        if (shadow_full_q) begin
          active_l_d    = shadow_l_q;
          active_r_d    = shadow_r_q;
          shadow_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
      end
      lrck_d  = bit_cnt_d[5];
      pos     = bit_cnt_d[4:0];
      word    = bit_cnt_d[5] ? active_r_q : active_l_q;
      shifted = word << (pos - 5'd1);
      data_d  = (pos != 5'd0 && int'(pos) <= SW) ? shifted[SW-1] : 1'b0;
    end

    ready_d = !shadow_full_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q     <= '0;
      lrck_q        <= 1'b0;
      data_q        <= 1'b0;
      ready_q       <= 1'b1;
      underrun_q    <= 1'b0;
      shadow_full_q <= 1'b0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      active_l_q    <= '0;
      active_r_q    <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      underrun_q    <= underrun_d;
      shadow_full_q <= shadow_full_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      active_l_q    <= active_l_d;
      active_r_q    <= active_r_d;
    end
  end

  assign sample_ready = ready_q;
  assign underrun     = underrun_q;
  assign I2S_LRCK     = lrck_q;
  assign I2S_DATA     = data_q;

endmodule
